csc_coef_ctrl: RTL and testbench
================================

Name: csc_coef_ctrl

Overview:
- Configuration controller for the RGB→YCbCr colour-space-conversion datapath.
- Holds a host-writable shadow bank: 9 signed 18-bit matrix coefficients plus a 9-bit chroma offset.
- On request, commits the shadow bank to an active bank at the next frame boundary (vsync rising edge), so coefficients never change mid-frame.
- Drives the coefficient/offset inputs of the converter and provides registered readback.

Parameters:
- CW, 18, coefficient width (two's complement, Q1.17 scaling as used by the converter).
- OW, 9, offset width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ce  in  1  video clock enable; gates vsync sampling and commit.
- vsync_in  in  1  video vsync, same timing as the converter input.
- wr_en  in  1  host write strobe, one write per cycle, not gated by ce.
- wr_addr  in  4  0..8 = coefficient A_11..A_33 (row-major); 9 = offset; 10..15 invalid.
- wr_data  in  18  write data; offset uses bits [8:0].
- commit  in  1  single-cycle request to apply the shadow bank at the next frame boundary.
- rd_addr  in  4  readback address, same map as wr_addr.
- rd_sel  in  1  0 = read active bank, 1 = read shadow bank.
- rd_data  out  18  registered readback; offset is zero-extended.
- wr_err  out  1  one-cycle pulse on a write to an invalid address.
- pending  out  1  commit requested, swap not yet done.
- commit_done  out  1  one-cycle pulse in the cycle the active bank updates.
- coef_flat  out  162  active bank; A_11 in [17:0] through A_33 in [161:144].
- offset  out  9  active offset.

Behaviour:
- **Reset defaults.** Both banks reset to: A_11=18'h09917, A_12=18'h12C8B, A_13=18'h03A5E, A_21=18'h3A9A0, A_22=18'h35660, A_23=18'h10000, A_31=18'h10000, A_32=18'h329A0, A_33=18'h3D660, offset=9'h080. Also on reset: rd_data=0, wr_err=0, pending=0, commit_done=0, vsync_q=0.
- **Writes.**
  - wr_en with addr 0..9 updates the shadow entry at the next clk edge, regardless of ce.
  - addr 10..15: no state change; wr_err=1 in the following cycle.
- **Frame edge.** vsync_q is updated only when ce=1. frame_edge = ce & vsync_in & ~vsync_q.
- **State machine** (2 states):
  - IDLE: commit=1 → ARMED, pending=1.
  - ARMED: frame_edge → copy shadow to active (all 10 entries atomically, same clock edge), commit_done=1 next cycle, pending=0, return to IDLE.
  - Further commits while ARMED are absorbed (no queueing).
- **Simultaneous events.**
  - commit and frame_edge in the same cycle while IDLE: swap happens in that cycle (pending never observed high); commit_done pulses next cycle.
  - wr_en in the swap cycle: active receives the pre-write shadow value; the write lands in shadow only and needs a later commit.
  - commit in the swap cycle while ARMED: consumed by that swap, not re-armed.
- **Outputs.** coef_flat and offset are driven directly from active registers and change only on a swap edge or reset. Downstream sees new values from the first frame_edge cycle onward, before the first active pixel of the frame.
- **Readback.** rd_data <= selected bank[rd_addr], 1-cycle latency; addr 10..15 reads 0. A shadow write is visible on readback in the cycle after the write.
- **Reset mid-operation.** Asserting rst while ARMED discards the request; both banks return to defaults immediately (asynchronous).
- **ce=0.** Freezes vsync_q and suppresses frame_edge; writes and readback continue.
- Purely registered; no combinational path from wr_* to coef_flat.

Test Plan:
- Reset, then read active addr 0..9 → 18'h09917 … 18'h3D660, 18'h080; coef_flat[17:0]=18'h09917; pending=0.
- Write addr 1=18'h20000, commit, toggle vsync 0→1 with ce=1 → pending high until the edge; coef_flat[35:18]=18'h20000 after the edge; commit_done one pulse; shadow readback=18'h20000 before the swap while active still reads 18'h12C8B.
- Write addr 9=18'h3FF10 → offset unchanged until a commit+vsync edge, then offset=9'h110; readback=18'h00110.
- Write addr 12 → wr_err pulses once; readback of banks unchanged.
- commit + frame_edge same cycle, with wr_en addr 0=18'h00001 also in that cycle → active A_11 = prior shadow value, shadow A_11=18'h00001, commit_done pulses, pending stays 0.
- vsync edge with ce=0 while ARMED → no swap; with ce=1 on a later edge → swap. rst asserted while ARMED → pending=0, defaults restored.

Source files
------------

// File: rtl/csc_coef_ctrl.sv
// Coefficient/offset controller for the RGB->YCbCr converter: a host-written shadow
// bank is copied into the active bank on the first vsync rising edge after a commit.
module csc_coef_ctrl #(
   parameter int CW = 18,
   parameter int OW = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic             vsync_in,
   input  logic             wr_en,
   input  logic [3:0]       wr_addr,
   input  logic [CW-1:0]    wr_data,
   input  logic             commit,
   input  logic [3:0]       rd_addr,
   input  logic             rd_sel,
   output logic [CW-1:0]    rd_data,
   output logic             wr_err,
   output logic             pending,
   output logic             commit_done,
   output logic [9*CW-1:0]  coef_flat,
   output logic [OW-1:0]    offset
);

   localparam logic [CW-1:0] DEF_COEF [9] = '{
      18'h09917, 18'h12C8B, 18'h03A5E,
      18'h3A9A0, 18'h35660, 18'h10000,
      18'h10000, 18'h329A0, 18'h3D660
   };
   localparam logic [OW-1:0] DEF_OFF = 9'h080;

   typedef enum logic {IDLE, ARMED} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] sh_coef  [9];
   logic [OW-1:0] sh_off;
   logic [CW-1:0] act_coef [9];
   logic [OW-1:0] act_off;
   logic          vsync_q;
   logic          frame_edge;
   logic          swap;
   logic [CW-1:0] rd_word;

   assign frame_edge = ce & vsync_in & ~vsync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vsync_q <= 1'b0;
      end else if (ce) begin
         vsync_q <= vsync_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A commit that coincides with a frame edge swaps immediately and never arms.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (commit && !frame_edge) state_nxt = ARMED;
         ARMED:   if (frame_edge) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      swap    = 1'b0;
      pending = 1'b0;
      case (state)
         IDLE:    swap = commit & frame_edge;
         ARMED: begin
            swap    = frame_edge;
            pending = 1'b1;
         end
         default: swap = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 9; i++) sh_coef[i] <= DEF_COEF[i];
         sh_off <= DEF_OFF;
      end else if (wr_en) begin
         if (wr_addr < 4'd9) begin
            sh_coef[wr_addr] <= wr_data;
         end else if (wr_addr == 4'd9) begin
            sh_off <= wr_data[OW-1:0];
         end
      end
   end

   // The copy samples the shadow before any same-cycle write lands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 9; i++) act_coef[i] <= DEF_COEF[i];
         act_off <= DEF_OFF;
      end else if (swap) begin
         for (int i = 0; i < 9; i++) act_coef[i] <= sh_coef[i];
         act_off <= sh_off;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         commit_done <= 1'b0;
         wr_err      <= 1'b0;
      end else begin
         commit_done <= swap;
         wr_err      <= wr_en & (wr_addr > 4'd9);
      end
   end

   always_comb begin
      rd_word = '0;
      if (rd_addr < 4'd9) begin
         rd_word = rd_sel ? sh_coef[rd_addr] : act_coef[rd_addr];
      end else if (rd_addr == 4'd9) begin
         rd_word = {{(CW-OW){1'b0}}, (rd_sel ? sh_off : act_off)};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
      end else begin
         rd_data <= rd_word;
      end
   end

   for (genvar g = 0; g < 9; g++) begin : g_flat
      assign coef_flat[g*CW +: CW] = act_coef[g];
   end

   assign offset = act_off;

endmodule

// File: tb/tb_csc_coef_ctrl.sv
// Directed bench for csc_coef_ctrl: a small bank model plus a readback scoreboard
// queue, with immediate assertions at every comparison.
module tb_csc_coef_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         ce;
   logic         vsync_in;
   logic         wr_en;
   logic [3:0]   wr_addr;
   logic [17:0]  wr_data;
   logic         commit;
   logic [3:0]   rd_addr;
   logic         rd_sel;
   logic [17:0]  rd_data;
   logic         wr_err;
   logic         pending;
   logic         commit_done;
   logic [161:0] coef_flat;
   logic [8:0]   offset;

   int checks = 0;
   int errors = 0;

   logic [17:0] exp_sh  [10];
   logic [17:0] exp_act [10];
   logic [17:0] sb_q [$];

   localparam logic [17:0] DEF [10] = '{
      18'h09917, 18'h12C8B, 18'h03A5E, 18'h3A9A0, 18'h35660,
      18'h10000, 18'h10000, 18'h329A0, 18'h3D660, 18'h00080
   };

   csc_coef_ctrl dut (
      .clk(clk), .rst(rst), .ce(ce), .vsync_in(vsync_in),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit),
      .rd_addr(rd_addr), .rd_sel(rd_sel), .rd_data(rd_data), .wr_err(wr_err),
      .pending(pending), .commit_done(commit_done), .coef_flat(coef_flat),
      .offset(offset)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [161:0] obs, input logic [161:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [161:0] packed_act();
      logic [161:0] r;
      for (int i = 0; i < 9; i++) r[i*18 +: 18] = exp_act[i];
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 10; i++) begin
         exp_sh[i]  = DEF[i];
         exp_act[i] = DEF[i];
      end
   endtask

   task automatic model_swap();
      for (int i = 0; i < 10; i++) exp_act[i] = exp_sh[i];
   endtask

   task automatic model_write(input logic [3:0] a, input logic [17:0] d);
      if (a < 4'd9) exp_sh[a] = d;
      else if (a == 4'd9) exp_sh[a] = {9'd0, d[8:0]};
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_coef_flat"}, coef_flat, packed_act());
      check({tag, "_offset"}, {153'd0, offset}, {153'd0, exp_act[9][8:0]});
   endtask

   // Expected word is queued when the address is driven and popped once rd_data registers it.
   task automatic read_expect(input string tag, input logic sel, input logic [3:0] a);
      logic [17:0] e;
      rd_sel  = sel;
      rd_addr = a;
      if (a < 4'd10) sb_q.push_back(sel ? exp_sh[a] : exp_act[a]);
      else sb_q.push_back(18'd0);
      step();
      e = sb_q.pop_front();
      check(tag, {144'd0, rd_data}, {144'd0, e});
   endtask

   task automatic write(input logic [3:0] a, input logic [17:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      model_write(a, d);
      step();
      wr_en = 1'b0;
   endtask

   task automatic pulse_commit();
      commit = 1'b1;
      step();
      commit = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ce = 1'b1; vsync_in = 1'b0; wr_en = 1'b0; wr_addr = '0;
      wr_data = '0; commit = 1'b0; rd_addr = '0; rd_sel = 1'b0;
      model_reset();
      #1;
      check("rst_rd_data", {144'd0, rd_data}, 162'd0);
      check("rst_pending", {161'd0, pending}, 162'd0);
      check("rst_commit_done", {161'd0, commit_done}, 162'd0);
      check("rst_wr_err", {161'd0, wr_err}, 162'd0);
      step(); step();
      rst = 1'b0;
      step();
      check_outputs("rst");
      check("rst_a11", {144'd0, coef_flat[17:0]}, 162'h09917);
      for (int i = 0; i < 10; i++) read_expect("rst_read_active", 1'b0, 4'(i));
      read_expect("read_invalid", 1'b0, 4'd12);

      // Coefficient update through commit and a vsync edge
      write(4'd1, 18'h20000);
      read_expect("a12_shadow_pre", 1'b1, 4'd1);
      read_expect("a12_active_pre", 1'b0, 4'd1);
      check("a12_model_active", {144'd0, exp_act[1]}, 162'h12C8B);
      pulse_commit();
      check("c1_pending", {161'd0, pending}, 162'd1);
      step(); step();
      check("c1_pending_hold", {161'd0, pending}, 162'd1);
      check_outputs("c1_before_edge");
      vsync_in = 1'b1;
      step();
      model_swap();
      check("c1_commit_done", {161'd0, commit_done}, 162'd1);
      check("c1_pending_clear", {161'd0, pending}, 162'd0);
      check("c1_a12", {144'd0, coef_flat[35:18]}, 162'h20000);
      check_outputs("c1_after_edge");
      vsync_in = 1'b0;
      step();
      check("c1_done_single", {161'd0, commit_done}, 162'd0);

      // Offset update
      write(4'd9, 18'h3FF10);
      check("off_unchanged", {153'd0, offset}, 162'h080);
      read_expect("off_shadow", 1'b1, 4'd9);
      pulse_commit();
      vsync_in = 1'b1;
      step();
      model_swap();
      vsync_in = 1'b0;
      check("off_after_swap", {153'd0, offset}, 162'h110);
      read_expect("off_active", 1'b0, 4'd9);

      // Invalid write address
      write(4'd12, 18'h15555);
      check("wr_err_pulse", {161'd0, wr_err}, 162'd1);
      step();
      check("wr_err_single", {161'd0, wr_err}, 162'd0);
      read_expect("inv_shadow0", 1'b1, 4'd0);
      read_expect("inv_active0", 1'b0, 4'd0);
      read_expect("inv_shadow9", 1'b1, 4'd9);

      // Commit, frame edge and write all in one cycle while IDLE
      commit = 1'b1; vsync_in = 1'b1;
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 18'h00001;
      step();
      model_swap();
      model_write(4'd0, 18'h00001);
      commit = 1'b0; wr_en = 1'b0;
      check("sim_pending", {161'd0, pending}, 162'd0);
      check("sim_commit_done", {161'd0, commit_done}, 162'd1);
      check("sim_a11", {144'd0, coef_flat[17:0]}, 162'h09917);
      vsync_in = 1'b0;
      step();
      check("sim_done_single", {161'd0, commit_done}, 162'd0);
      check("sim_pending_after", {161'd0, pending}, 162'd0);
      read_expect("sim_shadow0", 1'b1, 4'd0);
      read_expect("sim_active0", 1'b0, 4'd0);

      // Vsync edge with ce low must not swap; a repeated commit is absorbed
      pulse_commit();
      pulse_commit();
      ce = 1'b0; vsync_in = 1'b1;
      step(); step();
      check("ce0_pending", {161'd0, pending}, 162'd1);
      check("ce0_no_done", {161'd0, commit_done}, 162'd0);
      check_outputs("ce0_no_swap");
      vsync_in = 1'b0;
      step();
      ce = 1'b1;
      step();
      vsync_in = 1'b1;
      step();
      model_swap();
      check("ce1_done", {161'd0, commit_done}, 162'd1);
      check("ce1_a11", {144'd0, coef_flat[17:0]}, 162'h00001);
      check_outputs("ce1_swap");
      vsync_in = 1'b0;
      step();
      check("ce1_not_rearmed", {161'd0, pending}, 162'd0);

      // Asynchronous reset while ARMED
      write(4'd2, 18'h0AAAA);
      pulse_commit();
      check("arm_pending", {161'd0, pending}, 162'd1);
      rst = 1'b1;
      #1;
      model_reset();
      check("rst_arm_pending", {161'd0, pending}, 162'd0);
      check_outputs("rst_arm");
      step();
      rst = 1'b0;
      step();
      read_expect("rst_arm_shadow2", 1'b1, 4'd2);
      read_expect("rst_arm_shadow0", 1'b1, 4'd0);
      vsync_in = 1'b1;
      step();
      vsync_in = 1'b0;
      check("rst_arm_no_swap", {161'd0, commit_done}, 162'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
